count_display: RTL and testbench



---
 rtl/count_display.sv | 185 ++++++++++++++++++
 tb/tb_count_display.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/count_display.sv
// count_display: sequential double-dabble BCD conversion of an 8-bit count,
// driving a 4-digit multiplexed 7-segment display with optional leading-zero blanking.
module count_display #(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          BLANK_LZ    = 1'b1,
   parameter bit          ACTIVE_LOW  = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] count,
   output logic [6:0] seg,
   output logic [3:0] an,
   output logic       conv_done
);

   localparam int unsigned REF_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);
   localparam logic [6:0] SEG_OFF   = ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [3:0] AN_OFF    = ACTIVE_LOW ? 4'hF  : 4'h0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_LATCH
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_load;
   logic              w_shift;
   logic              w_latch;

   logic [7:0]        r_bin;
   logic [11:0]       r_bcd;
   logic [11:0]       w_adj;
   logic [2:0]        r_shift_cnt;
   logic [3:0]        r_hund;
   logic [3:0]        r_tens;
   logic [3:0]        r_unit;

   logic [REF_W-1:0]  r_refresh;
   logic [1:0]        r_digit;
   logic [3:0]        w_nib;
   logic              w_blank;
   logic [3:0]        w_an_hi;
   logic [6:0]        w_seg_hi;

   logic [6:0]        r_seg;
   logic [3:0]        r_an;
   logic              r_conv_done;

   function automatic logic [6:0] seg_code(input logic [3:0] nib);
      case (nib)
         4'd0:    seg_code = 7'h3F;
         4'd1:    seg_code = 7'h06;
         4'd2:    seg_code = 7'h5B;
         4'd3:    seg_code = 7'h4F;
         4'd4:    seg_code = 7'h66;
         4'd5:    seg_code = 7'h6D;
         4'd6:    seg_code = 7'h7D;
         4'd7:    seg_code = 7'h07;
         4'd8:    seg_code = 7'h7F;
         4'd9:    seg_code = 7'h6F;
         default: seg_code = 7'h00;
      endcase
   endfunction

   // Converter FSM: state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = S_SHIFT;
         S_SHIFT: if (r_shift_cnt == 3'd7) w_next = S_LATCH;
         S_LATCH: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_load  = (r_state == S_IDLE);
      w_shift = (r_state == S_SHIFT);
      w_latch = (r_state == S_LATCH);
   end

   // Add-3 correction on every BCD nibble that would overflow past 9 after the shift
   always_comb begin
      w_adj = r_bcd;
      for (int unsigned i = 0; i < 3; i++) begin
         if (r_bcd[4*i +: 4] >= 4'd5) begin
            w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_bin       <= '0;
         r_bcd       <= '0;
         r_shift_cnt <= '0;
         r_hund      <= '0;
         r_tens      <= '0;
         r_unit      <= '0;
         r_conv_done <= 1'b0;
      end else begin
         r_conv_done <= w_latch;
         if (w_load) begin
            r_bin       <= count;
            r_bcd       <= '0;
            r_shift_cnt <= '0;
         end
         if (w_shift) begin
            r_bcd       <= (w_adj << 1) | {11'd0, r_bin[7]};
            r_bin       <= {r_bin[6:0], 1'b0};
            r_shift_cnt <= r_shift_cnt + 3'd1;
         end
         if (w_latch) begin
            r_hund <= r_bcd[11:8];
            r_tens <= r_bcd[7:4];
            r_unit <= r_bcd[3:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_refresh <= '0;
         r_digit   <= '0;
      end else if (r_refresh == REF_LAST) begin
         r_refresh <= '0;
         r_digit   <= r_digit + 2'd1;
      end else begin
         r_refresh <= r_refresh + REF_W'(1);
      end
   end

   // Blanked digits keep their anode on; digit 3 is fully dark
   always_comb begin
      w_nib   = '0;
      w_blank = 1'b0;
      w_an_hi = '0;
      case (r_digit)
         2'd0: begin
            w_nib   = r_unit;
            w_an_hi = 4'b0001;
         end
         2'd1: begin
            w_nib   = r_tens;
            w_an_hi = 4'b0010;
            w_blank = BLANK_LZ && (r_hund == 4'd0) && (r_tens == 4'd0);
         end
         2'd2: begin
            w_nib   = r_hund;
            w_an_hi = 4'b0100;
            w_blank = BLANK_LZ && (r_hund == 4'd0);
         end
         default: begin
            w_blank = 1'b1;
         end
      endcase
      w_seg_hi = w_blank ? 7'h00 : seg_code(w_nib);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_seg <= SEG_OFF;
         r_an  <= AN_OFF;
      end else begin
         r_seg <= w_seg_hi ^ SEG_OFF;
         r_an  <= w_an_hi ^ AN_OFF;
      end
   end

   assign seg       = r_seg;
   assign an        = r_an;
   assign conv_done = r_conv_done;

endmodule

// File: tb/tb_count_display.sv
// Bench for count_display: table-driven display vectors plus a BCD scoreboard
// checked on every conv_done, with hand-written mid-conversion and reset sequences.
module tb_count_display;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] count;
   logic [6:0] seg, seg_nb;
   logic [3:0] an, an_nb;
   logic       done, done_nb;

   always #5 clk = ~clk;

   count_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1)) dut (
      .clk(clk), .reset(reset), .count(count),
      .seg(seg), .an(an), .conv_done(done)
   );

   count_display #(.REFRESH_DIV(4), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b1)) dut_nb (
      .clk(clk), .reset(reset), .count(count),
      .seg(seg_nb), .an(an_nb), .conv_done(done_nb)
   );

   typedef struct {
      logic [7:0] cnt;
      logic [6:0] su;
      logic [6:0] st;
      logic [6:0] sh;
      logic [6:0] st_nb;
      logic [6:0] sh_nb;
   } vec_t;

   vec_t        vecs[8];
   logic [11:0] exp_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   bit          idle_pending = 1'b0;
   int          gap = 0;

   function automatic logic [11:0] bcd_ref(input logic [7:0] v);
      int unsigned x;
      x = v;
      return {4'(x / 100), 4'((x / 10) % 10), 4'(x % 10)};
   endfunction

   function automatic logic [3:0] next_an(input logic [3:0] a);
      case (a)
         4'b1110: return 4'b1101;
         4'b1101: return 4'b1011;
         4'b1011: return 4'b1111;
         default: return 4'b1110;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive-side sampling model and conv_done scoreboard
   task automatic tick();
      bit          rst_edge;
      bit          idle_edge;
      logic [11:0] e;
      rst_edge  = reset;
      idle_edge = idle_pending && !reset;
      @(posedge clk);
      #1;
      if (rst_edge) begin
         exp_q.delete();
         idle_pending = 1'b1;
         gap = 0;
         check("done_in_reset", done, 1'b0);
      end else begin
         gap++;
         if (idle_edge) begin
            exp_q.push_back(bcd_ref(count));
            idle_pending = 1'b0;
         end
         if (done || done_nb) check("done_nb_match", done_nb, done);
         if (done) begin
            check("done_gap", gap, 10);
            gap = 0;
            idle_pending = 1'b1;
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL scoreboard: conv_done with no expected entry (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("digits", {dut.r_hund, dut.r_tens, dut.r_unit}, e);
               check("digits_nb", {dut_nb.r_hund, dut_nb.r_tens, dut_nb.r_unit}, e);
            end
         end
      end
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         tick();
         seen = done;
      end
      check({name, "_timeout"}, seen, 1'b1);
   endtask

   task automatic scan(input vec_t v);
      int         hits[4];
      logic [3:0] prev_an;
      logic [6:0] e, e_nb;
      hits = '{default: 0};
      prev_an = an;
      for (int i = 0; i < 16; i++) begin
         tick();
         case (an)
            4'b1110: begin e = v.su; e_nb = v.su;    hits[0]++; end
            4'b1101: begin e = v.st; e_nb = v.st_nb; hits[1]++; end
            4'b1011: begin e = v.sh; e_nb = v.sh_nb; hits[2]++; end
            default: begin
               e = 7'h7F; e_nb = 7'h7F; hits[3]++;
               check("an_idle", an, 4'b1111);
            end
         endcase
         check("seg", seg, e);
         check("seg_nb", seg_nb, e_nb);
         check("an_nb", an_nb, an);
         if (an != prev_an) check("an_order", an, next_an(prev_an));
         prev_an = an;
      end
      for (int k = 0; k < 4; k++) check("an_hold", hits[k], 4);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'd0,   7'h40, 7'h7F, 7'h7F, 7'h40, 7'h40};
      vecs[1] = '{8'd255, 7'h12, 7'h12, 7'h24, 7'h12, 7'h24};
      vecs[2] = '{8'd105, 7'h12, 7'h40, 7'h79, 7'h40, 7'h79};
      vecs[3] = '{8'd7,   7'h78, 7'h7F, 7'h7F, 7'h40, 7'h40};
      vecs[4] = '{8'd10,  7'h40, 7'h79, 7'h7F, 7'h79, 7'h40};
      vecs[5] = '{8'd99,  7'h10, 7'h10, 7'h7F, 7'h10, 7'h40};
      vecs[6] = '{8'd200, 7'h40, 7'h40, 7'h24, 7'h40, 7'h24};
      vecs[7] = '{8'd38,  7'h00, 7'h30, 7'h7F, 7'h30, 7'h40};

      reset = 1'b1;
      count = 8'd0;
      tick();
      tick();
      check("rst_an", an, 4'b1111);
      check("rst_seg", seg, 7'h7F);
      check("rst_done", done, 1'b0);
      check("rst_an_nb", an_nb, 4'b1111);
      check("rst_seg_nb", seg_nb, 7'h7F);

      reset = 1'b0;
      tick();
      check("start_an", an, 4'b1110);
      check("start_seg", seg, 7'h40);

      foreach (vecs[i]) begin
         count = vecs[i].cnt;
         wait_done("vec_a");
         wait_done("vec_b");
         tick();
         scan(vecs[i]);
      end

      // count changes three cycles after being sampled
      wait_done("mid_sync");
      count = 8'd20;
      tick();
      tick();
      tick();
      tick();
      count = 8'd200;
      wait_done("mid_first");
      check("mid_first", {dut.r_hund, dut.r_tens, dut.r_unit}, 12'h020);
      wait_done("mid_second");
      check("mid_second", {dut.r_hund, dut.r_tens, dut.r_unit}, 12'h200);

      for (int v = 0; v < 256; v++) begin
         wait_done("sweep");
         count = 8'(v);
      end
      wait_done("sweep_last");

      // reset lands on the fourth SHIFT cycle
      count = 8'd123;
      wait_done("rmid_sync");
      tick();
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      check("rmid_done", done, 1'b0);
      check("rmid_an", an, 4'b1111);
      check("rmid_seg", seg, 7'h7F);
      check("rmid_digits", {dut.r_hund, dut.r_tens, dut.r_unit}, 12'h000);
      reset = 1'b0;
      wait_done("rmid_after");
      check("rmid_result", {dut.r_hund, dut.r_tens, dut.r_unit}, 12'h123);
      check("rmid_gap_queue", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
